mem_arbiter: RTL and testbench

- Two-master arbiter that shares the single-port data/instruction memory between requesters, e.g. the cpu and a program loader or I/O DMA engine.
- Arbitration is round-robin per cycle. A lock/burst mechanism lets one master own the memory for several consecutive accesses, capped by MAX_BURST.
- Memory read latency is one cycle: data on mem_in is valid the cycle after the address is presented.
- The arbiter forwards read data and signals its validity per master.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port memory with lock/burst ownership.
// Read data returns one cycle after the grant; per-master rvalid tags the returning word.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  localparam int unsigned BCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);

  logic           last_q,     last_d;
  logic           lock_vld_q, lock_vld_d;
  logic           lock_own_q, lock_own_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           m0_rvalid_d, m1_rvalid_d;

  logic owner_req_c;
  logic other_req_c;
  logic any_gnt_c;
  logic gnt_id_c;
  logic same_run_c;

  assign owner_req_c = lock_own_q ? m1_req : m0_req;
  assign other_req_c = lock_own_q ? m0_req : m1_req;
  assign any_gnt_c   = m0_gnt | m1_gnt;
  assign gnt_id_c    = m1_gnt;
  // A nonzero count means the previous cycle was granted, and last names that master.
  assign same_run_c  = (lock_vld_q && (lock_own_q == gnt_id_c)) ||
                       ((burst_cnt_q != '0) && (last_q == gnt_id_c));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      lock_vld_q  <= 1'b0;
      lock_own_q  <= 1'b0;
      burst_cnt_q <= '0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_vld_q  <= lock_vld_d;
      lock_own_q  <= lock_own_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid   <= m0_rvalid_d;
      m1_rvalid   <= m1_rvalid_d;
    end
  end

  // Next-state: ownership, round-robin pointer, burst run length, read return
  always_comb begin
    last_d      = last_q;
    lock_vld_d  = 1'b0;
    lock_own_d  = lock_own_q;
    burst_cnt_d = '0;
    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
    if (any_gnt_c) begin
      last_d     = gnt_id_c;
      lock_own_d = gnt_id_c;
      lock_vld_d = gnt_id_c ? m1_lock : m0_lock;
      if (same_run_c) begin
        burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + BCW'(1);
      end else begin
        burst_cnt_d = BCW'(1);
      end
    end
  end

  // Outputs: grant decision and memory mux; reset forces the idle values at once
  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (rst_n) begin
      if (lock_vld_q && owner_req_c && (!other_req_c || (burst_cnt_q < BURST_MAX))) begin
        m0_gnt = ~lock_own_q;
        m1_gnt = lock_own_q;
      end else if (m0_req && m1_req) begin
        m0_gnt = last_q;
        m1_gnt = ~last_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
    if (m0_gnt) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_data = m0_wdata;
    end else if (m1_gnt) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_data = m1_wdata;
    end
  end

  assign busy  = any_gnt_c;
  assign rdata = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a run-length/ownership model checks every cycle,
// and literal expectations from hand-worked scenarios pin the model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_lock, m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_lock, m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem_in = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_in(mem_in), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behind the arbiter: one-cycle read latency, write at the grant edge
  logic [DW-1:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_data;
    mem_in <= tb_mem[mem_addr];
  end

  // Model: who was granted last cycle, with what lock, and how long the run of
  // consecutive grants to that master has lasted (capped at MB).
  logic [DW-1:0] model_mem [64];
  int   prev_g, run, rr_last;
  bit   prev_lock;
  bit   pend_rv [2];
  logic [DW-1:0] pend_rdata;

  always @(negedge clk) begin
    bit            rq [2];
    bit            lk [2];
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int g;
    rq[0] = m0_req; lk[0] = m0_lock; wr[0] = m0_we; ad[0] = m0_addr; wd[0] = m0_wdata;
    rq[1] = m1_req; lk[1] = m1_lock; wr[1] = m1_we; ad[1] = m1_addr; wd[1] = m1_wdata;
    if (!rst_n) begin
      prev_g = -1; run = 0; rr_last = 1; prev_lock = 0;
      pend_rv[0] = 0; pend_rv[1] = 0;
      check("rst_gnt", {m0_gnt, m1_gnt, busy}, 0);
      check("rst_mem", {mem_we, mem_addr, mem_data}, 0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    end else begin
      check("rvalid", {m0_rvalid, m1_rvalid}, {pend_rv[0], pend_rv[1]});
      if (pend_rv[0] || pend_rv[1]) check("rdata", rdata, pend_rdata);
      if (prev_g >= 0 && prev_lock && rq[prev_g] && (!rq[1 - prev_g] || run < MB)) g = prev_g;
      else if (rq[0] && rq[1]) g = 1 - rr_last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      else g = -1;
      check("gnt", {m0_gnt, m1_gnt}, {g == 0, g == 1});
      check("busy", busy, g >= 0);
      if (g >= 0) begin
        check("mem_bus", {mem_we, mem_addr, mem_data}, {wr[g], ad[g], wd[g]});
        run = (g == prev_g) ? ((run < MB) ? run + 1 : MB) : 1;
        rr_last = g;
        prev_lock = lk[g];
        pend_rv[0] = (g == 0) && !wr[0];
        pend_rv[1] = (g == 1) && !wr[1];
        pend_rdata = model_mem[ad[g]];
        if (wr[g]) model_mem[ad[g]] = wd[g];
      end else begin
        check("mem_idle", {mem_we, mem_addr, mem_data}, 0);
        run = 0; prev_lock = 0;
        pend_rv[0] = 0; pend_rv[1] = 0;
      end
      prev_g = g;
    end
  end

  task automatic idle();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic at_pos();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; idle();
    at_neg();
    at_pos();
    rst_n = 1;
  endtask

  initial begin
    bit exp3 [7];
    exp3[0] = 0; exp3[1] = 0; exp3[2] = 0; exp3[3] = 0; exp3[4] = 1; exp3[5] = 0; exp3[6] = 0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = 16'(i * 257);
      model_mem[i] = 16'(i * 257);
    end
    tb_mem[5] = 16'h1234;
    model_mem[5] = 16'h1234;
    idle();
    at_neg();
    check("reset_busy", busy, 0);
    check("reset_rvalid", {m0_rvalid, m1_rvalid}, 0);
    at_pos();
    rst_n = 1;

    // 1: single read from m0
    m0_req = 1; m0_addr = 6'd5;
    at_neg();
    check("t1_gnt", {m0_gnt, m1_gnt, mem_we, mem_addr}, {1'b1, 1'b0, 1'b0, 6'd5});
    at_pos(); idle();
    at_neg();
    check("t1_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    check("t1_rdata", rdata, 16'h1234);
    at_pos();

    // 2: both requesting, no lock: strict alternation from m0
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 6'd1; m1_addr = 6'd2;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check("t2_alt", {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      at_pos();
    end

    // 3: m0 locked burst capped at MB while m1 waits
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1; m0_addr = 6'd3; m1_addr = 6'd4;
    for (int i = 0; i < 7; i++) begin
      at_neg();
      check("t3_burst", {m0_gnt, m1_gnt}, exp3[i] ? 2'b01 : 2'b10);
      at_pos();
    end

    // 4: lock with the other master idle is never capped
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 6'd7;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      check("t4_hold", {m0_gnt, m1_gnt}, 2'b10);
      at_pos();
    end
    m1_req = 1; m1_addr = 6'd8;
    at_neg();
    check("t4_cap", {m0_gnt, m1_gnt}, 2'b01);
    at_pos();

    // 5: m1 writes, m0 reads it back
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 6'd63; m1_wdata = 16'hBEEF;
    at_neg();
    check("t5_write", {mem_we, mem_addr, mem_data}, {1'b1, 6'd63, 16'hBEEF});
    at_pos(); idle();
    m0_req = 1; m0_addr = 6'd63;
    at_neg();
    check("t5_no_wr_rvalid", {m0_gnt, m0_rvalid, m1_rvalid}, 3'b100);
    at_pos(); idle();
    at_neg();
    check("t5_readback", {m0_rvalid, rdata}, {1'b1, 16'hBEEF});
    at_pos();

    // 6: reset in the middle of back-to-back m0 reads
    do_reset();
    m0_req = 1; m0_addr = 6'd10;
    at_neg();
    check("t6_gnt", m0_gnt, 1);
    at_pos();
    at_neg();
    check("t6_rvalid_pre", m0_rvalid, 1);
    #1 rst_n = 0;
    #1;
    check("t6_rst_now", {m0_rvalid, m0_gnt, mem_we, mem_addr}, 0);
    at_neg();
    at_pos();
    rst_n = 1; m1_req = 1; m1_addr = 6'd11;
    at_neg();
    check("t6_first", {m0_gnt, m1_gnt}, 2'b10);
    at_pos(); idle();
    at_neg();
    at_pos();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
